demux1x2_stream: RTL and testbench
==================================

DEMUX1X2_STREAM -- requirements
Module: demux1x2_stream

Interface
- REQ-001 SHALL have parameter WIDTH, default 4: data width of every data port.
- REQ-002 SHALL have parameter DEPTH, fixed at 2: entries per output lane FIFO; no other value supported.
- REQ-003 `clk`  input  1  single clock; all state updates on rising edge.
- REQ-004 `rst`  input  1  asynchronous, active-high reset.
- REQ-005 `en`  input  1  routing enable; 0 = accepted words are discarded.
- REQ-006 `s`  input  1  lane select, sampled with the input word; 0 = lane 0, 1 = lane 1.
- REQ-007 `in_valid`  input  1  input word present.
- REQ-008 `in_data`  input  WIDTH  input word.
- REQ-009 `in_ready`  output  1  block accepts the input word this cycle.
- REQ-010 `out0_valid` / `out1_valid`  output  1 each  lane holds at least one word.
- REQ-011 `out0_data` / `out1_data`  output  WIDTH each  head word of the lane FIFO.
- REQ-012 `out0_ready` / `out1_ready`  input  1 each  downstream consumes the head word.
- REQ-013 `drop_count`  output  8  number of words discarded while en=0, saturating.

Function
- REQ-014 Input transfer SHALL occur when in_valid=1 and in_ready=1 on a rising edge; output transfer on lane k SHALL occur when outk_valid=1 and outk_ready=1.
- REQ-015 in_ready SHALL be combinational: 1 when en=0; otherwise it is the inverse of "selected lane full" (lane s holds DEPTH words).
- REQ-016 in_ready SHALL NOT depend on out0_ready or out1_ready: a full lane accepts no push even in a cycle where it pops.
- REQ-017 An accepted word with en=1 SHALL be written to the tail of lane s. It SHALL be visible on outs_valid/outs_data the following cycle, giving 1-cycle latency.
- REQ-018 An accepted word with en=0 SHALL NOT enter either lane. drop_count SHALL increment by 1 and hold at 255 once reached; there is no wrap.
- REQ-019 Each lane SHALL be an independent 2-entry FIFO with occupancy 0/1/2. Order SHALL be preserved within a lane; there is no ordering relation between lanes.
- REQ-020 Occupancy SHALL update as push-only +1, pop-only -1, and simultaneous push and pop unchanged. A simultaneous push and pop at occupancy 1 SHALL present the newly pushed word as head the next cycle.
- REQ-021 outk_valid SHALL be 1 exactly when lane k occupancy is nonzero. outk_data SHALL be the head word while valid and SHALL be held stable until popped.
- REQ-022 outk_ready asserted while lane k is empty SHALL have no effect.
- REQ-023 A change of en or s while in_valid=0 SHALL have no effect on state. A pop on one lane SHALL proceed regardless of en or s.
- REQ-024 Lane occupancy SHALL never exceed 2 and never go below 0 under any input sequence.

Reset
- REQ-025 While rst=1, regardless of clk, both lane occupancies SHALL be 0, out0_valid=out1_valid=0, out0_data=out1_data=0, and drop_count=0.
- REQ-026 Reset asserted mid-operation SHALL discard all buffered words immediately. No word held before reset SHALL appear on an output after reset deasserts.
- REQ-027 in_ready SHALL follow REQ-015 during reset, i.e. it reflects empty lanes. Any input transfer while rst=1 SHALL be ignored and SHALL NOT be counted.

Verification
- REQ-028 Reset, then en=1, s=0, in_data=4'hA for 1 cycle -> next cycle out0_valid=1, out0_data=A, out1_valid=0.
- REQ-029 en=1, s=1, push 3,5,7 back-to-back with out1_ready=0 -> in_ready=0 on the third word and lane1 holds 3,5. Then out1_ready=1 -> 3 then 5, after which the pending 7 is accepted and emitted.
- REQ-030 Lane0 holds 1 word, out0_ready=1 and a push of 4'h9 with s=0 in the same cycle -> occupancy stays 1 and out0_data=9 the next cycle.
- REQ-031 en=0, in_valid=1 held for 300 cycles -> in_ready=1 throughout, both outvalids stay 0, drop_count=255.
- REQ-032 Lane0 full with 2 words and drop_count=12, assert rst asynchronously between edges -> out0_valid=0 and drop_count=0 immediately. After release, a push with s=0 of 4'h6 -> out0_data=6.
- REQ-033 Lane0 full and s=0 gives in_ready=0; switch s=1 with lane1 empty -> in_ready=1 the same cycle and the word lands in lane1.

Source files
------------

// File: rtl/demux1x2_stream.sv
// Stream demultiplexer: routes each accepted word to one of two independent
// 2-entry output FIFOs, or discards it (and counts the drop) while disabled.
module demux1x2_stream #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             s,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out0_valid,
   output logic [WIDTH-1:0] out0_data,
   input  logic             out0_ready,
   output logic             out1_valid,
   output logic [WIDTH-1:0] out1_data,
   input  logic             out1_ready,
   output logic [7:0]       drop_count
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1. in_ready never looks at the output-side ready signals.

   localparam logic [1:0] FULL_CNT = 2'(DEPTH);

   // Each lane keeps its head word in head_q so the output is a plain register.
   logic [WIDTH-1:0] head_q [2];
   logic [WIDTH-1:0] head_d [2];
   logic [WIDTH-1:0] tail_q [2];
   logic [WIDTH-1:0] tail_d [2];
   logic [1:0]       cnt_q  [2];
   logic [1:0]       cnt_d  [2];
   logic [7:0]       drop_q;
   logic [7:0]       drop_d;

   logic             ready_w [2];
   logic             push_w  [2];
   logic             pop_w   [2];
   logic             full_sel;
   logic             accept;

   assign ready_w[0] = out0_ready;
   assign ready_w[1] = out1_ready;

   always_comb begin
      full_sel = ((s ? cnt_q[1] : cnt_q[0]) == FULL_CNT);
      in_ready = !en || !full_sel;
      accept   = in_valid && in_ready;

      drop_d = drop_q;
      if (accept && !en && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end

      for (int k = 0; k < 2; k++) begin
         push_w[k] = accept && en && (s == k[0]);
         pop_w[k]  = (cnt_q[k] != 2'd0) && ready_w[k];
         head_d[k] = head_q[k];
         tail_d[k] = tail_q[k];
         cnt_d[k]  = cnt_q[k];
         // A push alongside a pop can only happen at occupancy 1, since a full
         // lane blocks the push; the new word then becomes the head.
         if (push_w[k] && pop_w[k]) begin
            head_d[k] = in_data;
         end else if (push_w[k]) begin
            if (cnt_q[k] == 2'd0) begin
               head_d[k] = in_data;
            end else begin
               tail_d[k] = in_data;
            end
            cnt_d[k] = cnt_q[k] + 2'd1;
         end else if (pop_w[k]) begin
            head_d[k] = tail_q[k];
            cnt_d[k]  = cnt_q[k] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            head_q[k] <= '0;
            tail_q[k] <= '0;
            cnt_q[k]  <= 2'd0;
         end
         drop_q <= 8'd0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            head_q[k] <= head_d[k];
            tail_q[k] <= tail_d[k];
            cnt_q[k]  <= cnt_d[k];
         end
         drop_q <= drop_d;
      end
   end

   assign out0_valid = (cnt_q[0] != 2'd0);
   assign out1_valid = (cnt_q[1] != 2'd0);
   assign out0_data  = head_q[0];
   assign out1_data  = head_q[1];
   assign drop_count = drop_q;

endmodule

// File: tb/tb_demux1x2_stream.sv
// Randomised and directed bench for demux1x2_stream using per-lane queue
// models and a drop counter model.
module tb_demux1x2_stream;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         s = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_ready;
   logic         out0_valid;
   logic [W-1:0] out0_data;
   logic         out0_ready = 1'b0;
   logic         out1_valid;
   logic [W-1:0] out1_data;
   logic         out1_ready = 1'b0;
   logic [7:0]   drop_count;

   logic [W-1:0] exp_q0[$];
   logic [W-1:0] exp_q1[$];
   int           model_drop = 0;
   int           n_checks = 0;
   int           n_fail = 0;

   demux1x2_stream #(.WIDTH(W), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .s          (s),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out0_valid (out0_valid),
      .out0_data  (out0_data),
      .out0_ready (out0_ready),
      .out1_valid (out1_valid),
      .out1_data  (out1_data),
      .out1_ready (out1_ready),
      .drop_count (drop_count)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive at negedge, check in_ready, record the
   // expected effect of the transfer in the models.
   task automatic drive(input logic e, input logic sel, input logic v,
                        input logic [W-1:0] d, input logic r0, input logic r1);
      logic exp_rdy;
      logic acc;
      int   occ;
      @(negedge clk);
      en = e; s = sel; in_valid = v; in_data = d;
      out0_ready = r0; out1_ready = r1;
      #1;
      occ     = sel ? exp_q1.size() : exp_q0.size();
      exp_rdy = !e || (occ < 2);
      check("in_ready", int'(in_ready), int'(exp_rdy));
      acc = v && exp_rdy && !rst;
      #2;
      if (acc) begin
         if (e) begin
            if (sel) exp_q1.push_back(d);
            else     exp_q0.push_back(d);
         end else if (model_drop < 255) begin
            model_drop++;
         end
      end
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; out0_ready = 1'b0; out1_ready = 1'b0;
   endtask

   // Monitor: compares outputs against the queue heads once per cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            check("rst_out0_valid", int'(out0_valid), 0);
            check("rst_out1_valid", int'(out1_valid), 0);
            check("rst_out0_data", int'(out0_data), 0);
            check("rst_out1_data", int'(out1_data), 0);
            check("rst_drop_count", int'(drop_count), 0);
         end else begin
            check("out0_valid", int'(out0_valid), int'(exp_q0.size() != 0));
            if (exp_q0.size() != 0) begin
               check("out0_data", int'(out0_data), int'(exp_q0[0]));
               if (out0_ready) void'(exp_q0.pop_front());
            end
            check("out1_valid", int'(out1_valid), int'(exp_q1.size() != 0));
            if (exp_q1.size() != 0) begin
               check("out1_data", int'(out1_data), int'(exp_q1[0]));
               if (out1_ready) void'(exp_q1.pop_front());
            end
            check("drop_count", int'(drop_count), model_drop);
         end
      end
   end

   task automatic release_reset();
      @(negedge clk);
      idle_inputs();
      rst = 1'b0;
   endtask

   initial begin
      // reset phase: transfers are ignored and not counted
      drive(1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 1'b1);
      release_reset();

      // single word to lane 0
      drive(1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

      // lane 1 fills, third word stalls, then drains through
      drive(1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);

      // simultaneous push and pop at occupancy 1
      drive(1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

      // en/s changes with no valid word leave state alone
      for (int i = 0; i < 4; i++)
         drive(1'(i), 1'(i >> 1), 1'b0, 4'hF, 1'b0, 1'b0);

      // lane 0 full, lane 1 still accepts
      drive(1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

      // long drop run saturates the counter
      for (int i = 0; i < 300; i++)
         drive(1'b0, 1'(i), 1'b1, 4'(i), 1'(i), 1'(i >> 1));
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);

      // asynchronous reset mid-operation with lane 0 full
      @(negedge clk); rst = 1'b1; idle_inputs();
      exp_q0.delete(); exp_q1.delete(); model_drop = 0;
      release_reset();
      for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
      @(negedge clk);
      idle_inputs();
      #4;
      rst = 1'b1;
      #1;
      check("async_out0_valid", int'(out0_valid), 0);
      check("async_drop_count", int'(drop_count), 0);
      check("async_in_ready", int'(in_ready), 1);
      exp_q0.delete(); exp_q1.delete(); model_drop = 0;
      drive(1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
      release_reset();
      drive(1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);

      // randomised traffic
      for (int i = 0; i < 500; i++)
         drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));

      // drain
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
      @(negedge clk);
      #5;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
